dvi_src_sched: RTL

- Frame-synchronous pixel-source scheduler in front of the DVI encoder path.
- Shares the DVI output between two requesters, A (game renderer) and B (menu/overlay renderer), with round-robin arbitration.
- Emits a built-in colour-bar test pattern when neither requester is active, and black during a post-reset warm-up.
- Source changes occur only at frame boundaries, so no frame is ever torn. The registered colour output meets the encoder's fixed one-cycle colour-delay budget.

---
 rtl/dvi_src_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dvi_src_sched.sv
// Frame-synchronous pixel-source scheduler: round-robin between two renderers, colour bars when idle.
// Optional frame counter enabled by defining DVI_SRC_SCHED_FRAME_CNT_EN.
module dvi_src_sched #(
  parameter int unsigned COLOR_W        = 8,
  parameter int unsigned X_POS_W        = 10,
  parameter int unsigned Y_POS_W        = 10,
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter int unsigned BAR_W          = 80
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               vsync_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  input  logic               req_a_i,
  input  logic               req_b_i,
  input  logic [COLOR_W-1:0] red_a_i,
  input  logic [COLOR_W-1:0] green_a_i,
  input  logic [COLOR_W-1:0] blue_a_i,
  input  logic [COLOR_W-1:0] red_b_i,
  input  logic [COLOR_W-1:0] green_b_i,
  input  logic [COLOR_W-1:0] blue_b_i,
  output logic               gnt_a_o,
  output logic               gnt_b_o,
  output logic               test_o,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic [15:0]        frame_cnt_o
);

  localparam int unsigned WU_W  = (STARTUP_FRAMES < 2) ? 1 : $clog2(STARTUP_FRAMES + 1);
  localparam int unsigned PIX_W = (BAR_W < 2) ? 1 : $clog2(BAR_W + 1);

  typedef enum logic [1:0] {BLANK, TEST, RUN_A, RUN_B} state_t;

  state_t          state;
  state_t          arb;
  logic            vs_q;
  logic            fb;
  logic            last_gnt_b;
  logic [WU_W-1:0] wu_cnt;

  logic unused_y;
  assign unused_y = ^y_i;

  assign fb = vsync_i & ~vs_q;

  always_comb begin
    arb = TEST;
    if (state == RUN_A && req_a_i)      arb = RUN_A;
    else if (state == RUN_B && req_b_i) arb = RUN_B;
    else if (req_a_i && req_b_i)        arb = last_gnt_b ? RUN_A : RUN_B;
    else if (req_a_i)                   arb = RUN_A;
    else if (req_b_i)                   arb = RUN_B;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= BLANK;
      vs_q       <= 1'b0;
      wu_cnt     <= WU_W'(STARTUP_FRAMES);
      last_gnt_b <= 1'b1;
      gnt_a_o    <= 1'b0;
      gnt_b_o    <= 1'b0;
      test_o     <= 1'b0;
    end else begin
      vs_q <= vsync_i;
      if (fb) begin
        if (state == BLANK && wu_cnt != WU_W'(1)) begin
          wu_cnt <= wu_cnt - WU_W'(1);
        end else begin
          state   <= arb;
          gnt_a_o <= (arb == RUN_A);
          gnt_b_o <= (arb == RUN_B);
          test_o  <= (arb == TEST);
          if (arb == RUN_A) last_gnt_b <= 1'b0;
          if (arb == RUN_B) last_gnt_b <= 1'b1;
        end
      end
    end
  end

  // Counters track the bar of the current pixel assuming x advances by one per clock.
  logic [PIX_W-1:0] pix_q, pix_cur;
  logic [2:0]       bar_q, bar_cur;

  always_comb begin
    pix_cur = '0;
    bar_cur = '0;
    if (x_i != '0) begin
      if (pix_q == PIX_W'(BAR_W - 1)) begin
        pix_cur = '0;
        bar_cur = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
      end else begin
        pix_cur = pix_q + PIX_W'(1);
        bar_cur = bar_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q   <= '0;
      bar_q   <= '0;
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else begin
      pix_q <= pix_cur;
      bar_q <= bar_cur;
      case (state)
        RUN_A: begin
          red_o   <= red_a_i;
          green_o <= green_a_i;
          blue_o  <= blue_a_i;
        end
        RUN_B: begin
          red_o   <= red_b_i;
          green_o <= green_b_i;
          blue_o  <= blue_b_i;
        end
        TEST: begin
          red_o   <= {COLOR_W{~bar_cur[1]}};
          green_o <= {COLOR_W{~bar_cur[2]}};
          blue_o  <= {COLOR_W{~bar_cur[0]}};
        end
        default: begin
          red_o   <= '0;
          green_o <= '0;
          blue_o  <= '0;
        end
      endcase
    end
  end

`ifdef DVI_SRC_SCHED_FRAME_CNT_EN
  logic [15:0] fcnt;
  always_ff @(posedge clk_i) begin
    if (rst_i)   fcnt <= '0;
    else if (fb) fcnt <= fcnt + 16'd1;
  end
  assign frame_cnt_o = fcnt;
`else
  assign frame_cnt_o = '0;
`endif

endmodule
